// File: rtl/wash_if.sv
// wash_if: order inputs, admin price inputs and billing outputs of wash_billing
interface wash_if;
  logic        on;
  logic        start;
  logic [1:0]  size;
  logic        dry_en;
  logic        finish;
  logic        pickup;
  logic [11:0] dy_price;
  logic [11:0] s_price;
  logic [11:0] m_price;
  logic [11:0] b_price;
  logic [11:0] setfine;
  logic [11:0] bill;
  logic [11:0] profit;
  logic [11:0] runtime;
  logic        busy;
  logic        settled;
  logic [2:0]  st;
  modport master (
    output on, start, size, dry_en, finish, pickup,
    output dy_price, s_price, m_price, b_price, setfine,
    input  bill, profit, runtime, busy, settled, st
  );
  modport slave (
    input  on, start, size, dry_en, finish, pickup,
    input  dy_price, s_price, m_price, b_price, setfine,
    output bill, profit, runtime, busy, settled, st
  );
endinterface

// File: rtl/wash_billing.sv
// wash_billing: laundry order FSM with BCD billing, pickup fines, takings and powered-on runtime
module wash_billing #(
  parameter int TICK_DIV  = 100000000,
  parameter int GRACE_S   = 10,
  parameter int RT_UNIT_S = 60
) (
  input logic   clk,
  input logic   rst,
  wash_if.slave bus
);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int GW = $clog2(GRACE_S + 1);
  localparam int RW = $clog2(RT_UNIT_S + 1);
  typedef enum logic [2:0] {IDLE = 3'd0, QUOTE = 3'd1, RUN = 3'd2, HOLD = 3'd3, SETTLE = 3'd4} state_t;
  state_t state, state_n;
  logic [TW-1:0] tick_cnt;
  logic [GW-1:0] grace_cnt;
  logic [RW-1:0] rt_cnt;
  logic [11:0] bill, profit, runtime, size_price;
  logic [1:0] ord_size;
  logic ord_dry, tick, fine_due, rt_due;
  function automatic logic [3:0] clamp9(input logic [3:0] x);
    return x > 4'd9 ? 4'd9 : x;
  endfunction
  // digit-wise decimal add; a carry out of the hundreds digit saturates
  function automatic logic [11:0] bcd_add(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] r;
    logic [4:0] s;
    logic c;
    r = 12'h000;
    c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s = {1'b0, clamp9(a[i*4 +: 4])} + {1'b0, clamp9(b[i*4 +: 4])} + {4'b0, c};
      c = s > 5'd9;
      r[i*4 +: 4] = c ? 4'(s - 5'd10) : s[3:0];
    end
    return c ? 12'h999 : r;
  endfunction
  assign tick       = bus.on && tick_cnt == TW'(TICK_DIV - 1);
  assign fine_due   = state == HOLD && tick && grace_cnt == GW'(GRACE_S - 1);
  assign rt_due     = tick && rt_cnt == RW'(RT_UNIT_S - 1);
  assign size_price = ord_size == 2'd1 ? bus.s_price :
                      ord_size == 2'd2 ? bus.m_price :
                      ord_size == 2'd3 ? bus.b_price : 12'h000;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (bus.start && (bus.size != 2'd0 || bus.dry_en)) ? QUOTE : IDLE;
      QUOTE:   state_n = RUN;
      RUN:     state_n = bus.finish ? HOLD : RUN;
      HOLD:    state_n = bus.pickup ? SETTLE : HOLD;
      SETTLE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (!bus.on) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt  <= '0;
      grace_cnt <= '0;
      rt_cnt    <= '0;
      bill      <= 12'h000;
      profit    <= 12'h000;
      runtime   <= 12'h000;
      ord_size  <= 2'd0;
      ord_dry   <= 1'b0;
    end else begin
      tick_cnt  <= (state == RUN && bus.finish) || tick ? '0 : bus.on ? tick_cnt + TW'(1) : tick_cnt;
      grace_cnt <= state != HOLD || fine_due ? '0 : tick ? grace_cnt + GW'(1) : grace_cnt;
      if (tick) rt_cnt <= rt_due ? '0 : rt_cnt + RW'(1);
      if (rt_due) runtime <= bcd_add(runtime, 12'h001);
      if (state == IDLE && state_n == QUOTE) begin
        ord_size <= bus.size;
        ord_dry  <= bus.dry_en;
      end
      // a fine due on the pickup cycle still lands before settlement
      if (!bus.on) bill <= 12'h000;
      else if (state == QUOTE) bill <= bcd_add(size_price, ord_dry ? bus.dy_price : 12'h000);
      else if (fine_due) bill <= bcd_add(bill, bus.setfine);
      if (state == SETTLE && bus.on) profit <= bcd_add(profit, bill);
    end
  end
  assign bus.bill    = bill;
  assign bus.profit  = profit;
  assign bus.runtime = runtime;
  assign bus.busy    = state != IDLE;
  assign bus.settled = state == SETTLE;
  assign bus.st      = state;
endmodule
